// File: rtl/rc4_pkg.sv
// Shared definitions for the arcfour key-search scheduler: FSM encoding and chunk sizing.
package rc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISPATCH  = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_SUCCESS   = 3'd3,
    ST_EXHAUSTED = 3'd4
  } sched_state_t;

  // Default chunk is 2^16 keys; instances may shrink it for short key spaces.
  localparam int DEFAULT_CHUNK_LOG = 16;
  localparam longint unsigned DEFAULT_CHUNK_SIZE = 64'd1 << DEFAULT_CHUNK_LOG;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible (req & ~mask) core at or after pointer.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [LOG_N-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [LOG_N-1:0] index,
  output logic             valid
);

  logic [N-1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    int               pos;
    logic [LOG_N-1:0] pos_idx;
    grant   = '0;
    index   = '0;
    valid   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(pointer) + i;
      if (pos >= N) pos = pos - N;
      pos_idx = LOG_N'(pos);
      if (!valid && eligible[pos_idx]) begin
        valid          = 1'b1;
        grant[pos_idx] = 1'b1;
        index          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/key_chunk_scheduler.sv
// Hands out fixed-size key chunks to arcfour cores round-robin and collects done/found reports.
// Handshake: a core holds req while idle; a one-cycle grant (with base/last) answers it, and the
// core owns that chunk until it pulses chunk_done or found; kill returns every core to idle.
module key_chunk_scheduler
  import rc4_pkg::*;
#(
  parameter int                   NUM_CORES     = 8,
  parameter int                   LOG_NUM_CORES = 3,
  parameter int                   KEY_WIDTH     = 24,
  parameter int                   CHUNK_LOG     = DEFAULT_CHUNK_LOG,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = 24'h3FFFFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_CORES-1:0]           req,
  input  logic [NUM_CORES-1:0]           chunk_done,
  input  logic [NUM_CORES-1:0]           found,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] found_key,
  output logic [NUM_CORES-1:0]           grant,
  output logic [KEY_WIDTH-1:0]           grant_base,
  output logic [KEY_WIDTH-1:0]           grant_last,
  output logic                           kill,
  output logic                           busy,
  output logic                           success,
  output logic                           exhausted,
  output logic [LOG_NUM_CORES-1:0]       winner_core,
  output logic [KEY_WIDTH-1:0]           winner_key,
  output logic [2:0]                     state_dbg
);

  localparam int                 KW1         = KEY_WIDTH + 1;
  localparam logic [KEY_WIDTH:0] CHUNK_SIZE  = KW1'(1) << CHUNK_LOG;
  localparam logic [KEY_WIDTH:0] KEY_MAX_EXT = {1'b0, KEY_MAX};

  sched_state_t                 state_q, state_d;
  logic [KEY_WIDTH:0]           next_base_q, next_base_d;
  logic [NUM_CORES-1:0]         outstanding_q, outstanding_d;
  logic [LOG_NUM_CORES-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0]         grant_d;
  logic [KEY_WIDTH-1:0]         grant_base_d, grant_last_d;
  logic                         kill_d;
  logic [LOG_NUM_CORES-1:0]     winner_core_d;
  logic [KEY_WIDTH-1:0]         winner_key_d;

  logic [NUM_CORES-1:0]         arb_grant;
  logic [LOG_NUM_CORES-1:0]     arb_index;
  logic                         arb_valid;

  logic                         any_found;
  logic [LOG_NUM_CORES-1:0]     found_idx;
  logic [KEY_WIDTH-1:0]         found_key_sel;
  logic [KEY_WIDTH:0]           chunk_end;
  logic [KEY_WIDTH:0]           chunk_last;

  rr_arbiter #(
    .N     (NUM_CORES),
    .LOG_N (LOG_NUM_CORES)
  ) u_rr_arbiter (
    .req     (req),
    .mask    (outstanding_q),
    .pointer (rr_ptr_q),
    .grant   (arb_grant),
    .index   (arb_index),
    .valid   (arb_valid)
  );

  // Lowest-index reporting core wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    any_found     = |found;
    found_idx     = '0;
    found_key_sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (found[i]) begin
        found_idx     = LOG_NUM_CORES'(i);
        found_key_sel = found_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  // Chunk end computed one bit wider so the final chunk cannot wrap past zero.
  always_comb begin
    chunk_end  = next_base_q + CHUNK_SIZE - KW1'(1);
    chunk_last = (chunk_end > KEY_MAX_EXT) ? KEY_MAX_EXT : chunk_end;
  end

  always_comb begin
    state_d       = state_q;
    next_base_d   = next_base_q;
    outstanding_d = outstanding_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = '0;
    grant_base_d  = '0;
    grant_last_d  = '0;
    kill_d        = 1'b0;
    winner_core_d = winner_core;
    winner_key_d  = winner_key;

    case (state_q)
      ST_IDLE, ST_SUCCESS, ST_EXHAUSTED: begin
        if (start) begin
          state_d       = ST_DISPATCH;
          next_base_d   = '0;
          outstanding_d = '0;
          rr_ptr_d      = '0;
          winner_core_d = '0;
          winner_key_d  = '0;
        end
      end
      ST_DISPATCH, ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          kill_d  = 1'b1;
        end else if (any_found) begin
          state_d       = ST_SUCCESS;
          kill_d        = 1'b1;
          winner_core_d = found_idx;
          winner_key_d  = found_key_sel;
        end else begin
          outstanding_d = outstanding_q & ~chunk_done;
          if (state_q == ST_DISPATCH) begin
            if (arb_valid) begin
              grant_d       = arb_grant;
              grant_base_d  = next_base_q[KEY_WIDTH-1:0];
              grant_last_d  = chunk_last[KEY_WIDTH-1:0];
              next_base_d   = next_base_q + CHUNK_SIZE;
              outstanding_d = outstanding_d | arb_grant;
              rr_ptr_d      = (arb_index == LOG_NUM_CORES'(NUM_CORES - 1))
                              ? '0 : arb_index + LOG_NUM_CORES'(1);
              if (chunk_last == KEY_MAX_EXT) state_d = ST_DRAIN;
            end
          end else if (outstanding_q == '0) begin
            state_d = ST_EXHAUSTED;
            kill_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      next_base_q   <= '0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
      grant         <= '0;
      grant_base    <= '0;
      grant_last    <= '0;
      kill          <= 1'b0;
      busy          <= 1'b0;
      success       <= 1'b0;
      exhausted     <= 1'b0;
      winner_core   <= '0;
      winner_key    <= '0;
    end else begin
      state_q       <= state_d;
      next_base_q   <= next_base_d;
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
      grant         <= grant_d;
      grant_base    <= grant_base_d;
      grant_last    <= grant_last_d;
      kill          <= kill_d;
      busy          <= (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
      success       <= (state_d == ST_SUCCESS);
      exhausted     <= (state_d == ST_EXHAUSTED);
      winner_core   <= winner_core_d;
      winner_key    <= winner_key_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_key_chunk_scheduler.sv
// Directed bench for key_chunk_scheduler: two instances (KEY_MAX 63 and 40) share stimulus.
module tb_key_chunk_scheduler;
  import rc4_pkg::*;

  localparam int NC  = 4;
  localparam int LNC = 2;
  localparam int KW  = 24;
  localparam int CL  = 4;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [NC-1:0]     req, chunk_done, found;
  logic [NC*KW-1:0]  found_key;

  logic [NC-1:0]     grant_a, grant_b;
  logic [KW-1:0]     grant_base_a, grant_last_a, grant_base_b, grant_last_b;
  logic              kill_a, busy_a, success_a, exhausted_a;
  logic              kill_b, busy_b, success_b, exhausted_b;
  logic [LNC-1:0]    winner_core_a, winner_core_b;
  logic [KW-1:0]     winner_key_a, winner_key_b;
  logic [2:0]        state_dbg_a, state_dbg_b;

  key_chunk_scheduler #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW), .CHUNK_LOG(CL),
                        .KEY_MAX(24'd63)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .req(req),
    .chunk_done(chunk_done), .found(found), .found_key(found_key),
    .grant(grant_a), .grant_base(grant_base_a), .grant_last(grant_last_a), .kill(kill_a),
    .busy(busy_a), .success(success_a), .exhausted(exhausted_a),
    .winner_core(winner_core_a), .winner_key(winner_key_a), .state_dbg(state_dbg_a));

  key_chunk_scheduler #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW), .CHUNK_LOG(CL),
                        .KEY_MAX(24'd40)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .req(req),
    .chunk_done(chunk_done), .found(found), .found_key(found_key),
    .grant(grant_b), .grant_base(grant_base_b), .grant_last(grant_last_b), .kill(kill_b),
    .busy(busy_b), .success(success_b), .exhausted(exhausted_b),
    .winner_core(winner_core_b), .winner_key(winner_key_b), .state_dbg(state_dbg_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [KW-1:0]  exp_q[$];
  logic [LNC-1:0] exp_core_q[$];
  logic [KW-1:0]  exp_b_q[$];
  logic [LNC-1:0] exp_core_b_q[$];
  int  kill_cnt_a, kill_cnt_b;
  bit  auto_done, track_b;
  int  cnt[NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_last(input logic [31:0] base, input logic [31:0] kmax);
    logic [31:0] e;
    e = base + (32'd1 << CL) - 32'd1;
    return (e > kmax) ? kmax : e;
  endfunction

  task automatic push_a(input logic [KW-1:0] base, input logic [LNC-1:0] core);
    exp_q.push_back(base);
    exp_core_q.push_back(core);
  endtask

  // One clock: clear pulses and fire auto chunk_done after the edge, then observe at negedge.
  task automatic cycle();
    logic [KW-1:0]  base;
    logic [LNC-1:0] core;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; found = '0; chunk_done = '0;
    for (int i = 0; i < NC; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) chunk_done[i] = 1'b1;
      end
    end
    @(negedge clk);
    if (kill_a) kill_cnt_a++;
    if (kill_b) kill_cnt_b++;
    if (grant_a != '0) begin
      if (exp_q.size() == 0) check("grant_a_unexpected", grant_a, 0);
      else begin
        base = exp_q.pop_front();
        core = exp_core_q.pop_front();
        check("grant_a_core", grant_a, 32'd1 << core);
        check("grant_a_base", grant_base_a, base);
        check("grant_a_last", grant_last_a, model_last(base, 63));
      end
      if (auto_done)
        for (int i = 0; i < NC; i++) if (grant_a[i]) cnt[i] = 3;
    end
    if (track_b && grant_b != '0) begin
      if (exp_b_q.size() == 0) check("grant_b_unexpected", grant_b, 0);
      else begin
        base = exp_b_q.pop_front();
        core = exp_core_b_q.pop_front();
        check("grant_b_core", grant_b, 32'd1 << core);
        check("grant_b_base", grant_base_b, base);
        check("grant_b_last", grant_last_b, model_last(base, 40));
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    req = '0; chunk_done = '0; found = '0; found_key = '0;
    auto_done = 1'b0; track_b = 1'b0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    kill_cnt_a = 0; kill_cnt_b = 0;

    #12;
    check("rst_grant", grant_a, 0);
    check("rst_base", grant_base_a, 0);
    check("rst_last", grant_last_a, 0);
    check("rst_kill", kill_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_success", success_a, 0);
    check("rst_exhausted", exhausted_a, 0);
    check("rst_winner_core", winner_core_a, 0);
    check("rst_winner_key", winner_key_a, 0);
    check("rst_state", state_dbg_a, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;

    // found while idle must be ignored
    found = 4'b0001;
    found_key[0 +: KW] = 24'h7;
    cycle();
    check("idle_found_success", success_a, 0);
    check("idle_found_state", state_dbg_a, ST_IDLE);
    check("idle_found_kill", kill_a, 0);

    // full sweep to exhaustion on both instances
    req = '1; auto_done = 1'b1; track_b = 1'b1;
    push_a(0, 0); push_a(16, 1); push_a(32, 2); push_a(48, 3);
    exp_b_q = '{24'd0, 24'd16, 24'd32};
    exp_core_b_q = '{2'd0, 2'd1, 2'd2};
    kill_cnt_a = 0; kill_cnt_b = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exhausted_a && exhausted_b) break;
      cycle();
    end
    cycle(); cycle();
    check("sweep_exhausted_a", exhausted_a, 1);
    check("sweep_busy_a", busy_a, 0);
    check("sweep_success_a", success_a, 0);
    check("sweep_kills_a", kill_cnt_a, 1);
    check("sweep_grants_left_a", exp_q.size(), 0);
    check("sweep_exhausted_b", exhausted_b, 1);
    check("sweep_kills_b", kill_cnt_b, 1);
    check("sweep_grants_left_b", exp_b_q.size(), 0);

    // found during DRAIN
    auto_done = 1'b0; track_b = 1'b0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    kill_cnt_a = 0;
    push_a(0, 0); push_a(16, 1); push_a(32, 2); push_a(48, 3);
    start = 1'b1;
    repeat (5) cycle();
    check("drain_state", state_dbg_a, ST_DRAIN);
    check("drain_busy", busy_a, 1);
    check("drain_grants_left", exp_q.size(), 0);
    found = 4'b0100;
    found_key = '0;
    found_key[2*KW +: KW] = 24'h25;
    cycle();
    check("drain_found_success", success_a, 1);
    check("drain_found_core", winner_core_a, 2);
    check("drain_found_key", winner_key_a, 32'h25);
    check("drain_found_busy", busy_a, 0);
    cycle(); cycle();
    check("drain_found_kills", kill_cnt_a, 1);
    check("drain_found_hold", success_a, 1);

    // two simultaneous finders during DISPATCH
    kill_cnt_a = 0;
    push_a(0, 0); push_a(16, 1);
    start = 1'b1;
    cycle();
    check("restart_success_clr", success_a, 0);
    check("restart_winner_clr", winner_key_a, 0);
    cycle(); cycle();
    found = 4'b1010;
    found_key = '0;
    found_key[1*KW +: KW] = 24'h11;
    found_key[3*KW +: KW] = 24'h33;
    cycle();
    check("dual_found_grant", grant_a, 0);
    check("dual_found_success", success_a, 1);
    check("dual_found_core", winner_core_a, 1);
    check("dual_found_key", winner_key_a, 32'h11);
    check("dual_found_kill", kill_a, 1);
    check("dual_found_left", exp_q.size(), 0);

    // start while busy ignored, then abort (with found) in DISPATCH
    push_a(0, 0); push_a(16, 1);
    start = 1'b1;
    cycle(); cycle();
    start = 1'b1;
    cycle();
    check("busy_start_left", exp_q.size(), 0);
    abort = 1'b1;
    found = 4'b0001;
    found_key[0 +: KW] = 24'h3;
    cycle();
    check("abort_state", state_dbg_a, ST_IDLE);
    check("abort_busy", busy_a, 0);
    check("abort_kill", kill_a, 1);
    check("abort_success", success_a, 0);
    cycle();
    check("abort_kill_single", kill_a, 0);
    abort = 1'b1;
    cycle();
    check("idle_abort_kill", kill_a, 0);
    check("idle_abort_state", state_dbg_a, ST_IDLE);
    push_a(0, 0);
    start = 1'b1;
    cycle(); cycle();
    check("post_abort_regrant", exp_q.size(), 0);

    // asynchronous reset mid-DISPATCH
    check("pre_reset_grant", grant_a, 1);
    reset = 1'b0;
    #1;
    check("async_rst_grant", grant_a, 0);
    check("async_rst_base", grant_base_a, 0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_kill", kill_a, 0);
    check("async_rst_state", state_dbg_a, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) cycle();
    check("post_rst_busy", busy_a, 0);
    check("post_rst_kill", kill_a, 0);
    push_a(0, 0);
    start = 1'b1;
    cycle(); cycle();
    check("post_rst_regrant", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
